// File: rtl/fpu_op_sequencer.sv
// FPU-side scalar-stall sequencer: accepts one FP op, times its datapath latency, pulses completion.
// Latency: dp_start/halt_req combinational in accept cycle; fpu_complete/wb_valid registered at T+LAT.
// Backpressure: single op in flight; inst_valid is ignored while busy; flush aborts with a completion pulse.
module fpu_op_sequencer #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_FMA = 4,
  parameter int LAT_DIV = 12,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       inst_valid,
  input  logic       fpu_active,
  input  logic [6:0] inst_opcode,
  input  logic [6:0] inst_funct7,
  input  logic [4:0] inst_rd,
  input  logic       flush,
  output logic       halt_req,
  output logic       fpu_complete,
  output logic       dp_start,
  output logic [2:0] op_class,
  output logic       busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd
);

  // Op class encoding as seen on op_class.
  localparam logic [2:0] CLS_SINGLE = 3'd0;
  localparam logic [2:0] CLS_ADD    = 3'd1;
  localparam logic [2:0] CLS_MUL    = 3'd2;
  localparam logic [2:0] CLS_FMA    = 3'd3;
  localparam logic [2:0] CLS_DIV    = 3'd4;

  // Counter load values are LAT-1 so the counter hits zero in the completion cycle.
  // Every LAT_* must be in 1..2**CNT_W for these to fit.
  localparam logic [CNT_W-1:0] LD_SINGLE = '0;
  localparam logic [CNT_W-1:0] LD_ADD    = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] LD_MUL    = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] LD_FMA    = CNT_W'(LAT_FMA - 1);
  localparam logic [CNT_W-1:0] LD_DIV    = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cls_q, cls_d;
  logic [4:0]       rd_q, rd_d;
  logic             cmp_q, cmp_d;
  logic             wb_q, wb_d;

  logic [2:0]       dec_class;
  logic [CNT_W-1:0] dec_ld;
  logic             accept;

  // Decode the incoming instruction into a latency class and counter preload.
  always_comb begin
    dec_class = CLS_SINGLE;
    if (inst_opcode == 7'h43 || inst_opcode == 7'h47 ||
        inst_opcode == 7'h4B || inst_opcode == 7'h4F) begin
      dec_class = CLS_FMA;
    end else if (inst_opcode == 7'h53) begin
      casez (inst_funct7)
        7'b00000??: dec_class = CLS_ADD;
        7'b00001??: dec_class = CLS_ADD;
        7'b00010??: dec_class = CLS_MUL;
        7'b00011??: dec_class = CLS_DIV;
        7'b01011??: dec_class = CLS_DIV;
        default:    dec_class = CLS_SINGLE;
      endcase
    end
    case (dec_class)
      CLS_ADD: dec_ld = LD_ADD;
      CLS_MUL: dec_ld = LD_MUL;
      CLS_FMA: dec_ld = LD_FMA;
      CLS_DIV: dec_ld = LD_DIV;
      default: dec_ld = LD_SINGLE;
    endcase
  end

  // Accept only a fresh strobe in IDLE; a held fpu_active alone never restarts an op.
  always_comb begin
    accept = (state_q == IDLE) && inst_valid && fpu_active && !flush;
  end

  // Next-state logic: load on accept, count down in EXEC, natural completion beats flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    rd_d    = rd_q;
    cmp_d   = 1'b0;
    wb_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cls_d = dec_class;
          rd_d  = inst_rd;
          cnt_d = dec_ld;
          if (dec_ld == CNT_ZERO) begin
            // Single-cycle ops finish on the very next cycle without entering EXEC.
            cmp_d = 1'b1;
            wb_d  = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cmp_d   = 1'b1;
          wb_d    = 1'b1;
        end else if (flush) begin
          // Abort: release the checker's halt but suppress writeback.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          cmp_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State register; reset drops any in-flight op without a completion pulse.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      cls_q   <= CLS_SINGLE;
      rd_q    <= 5'd0;
      cmp_q   <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      rd_q    <= rd_d;
      cmp_q   <= cmp_d;
      wb_q    <= wb_d;
    end
  end

  // Output drive: halt only for multi-cycle classes; wb_rd is zero unless wb_valid.
  always_comb begin
    dp_start     = accept;
    halt_req     = accept && (dec_class != CLS_SINGLE);
    busy         = (state_q == EXEC);
    op_class     = cls_q;
    fpu_complete = cmp_q;
    wb_valid     = wb_q;
    wb_rd        = wb_q ? rd_q : 5'd0;
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: cycle-number model checked every cycle,
// plus hand-computed literal expectations at key cycles of each scenario.
module tb_fpu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       inst_valid = 1'b0;
  logic       fpu_active = 1'b0;
  logic [6:0] inst_opcode = 7'h0;
  logic [6:0] inst_funct7 = 7'h0;
  logic [4:0] inst_rd = 5'd0;
  logic       flush = 1'b0;
  logic       halt_req, fpu_complete, dp_start, busy, wb_valid;
  logic [2:0] op_class;
  logic [4:0] wb_rd;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  fpu_op_sequencer dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .inst_valid   (inst_valid),
    .fpu_active   (fpu_active),
    .inst_opcode  (inst_opcode),
    .inst_funct7  (inst_funct7),
    .inst_rd      (inst_rd),
    .flush        (flush),
    .halt_req     (halt_req),
    .fpu_complete (fpu_complete),
    .dp_start     (dp_start),
    .op_class     (op_class),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Class rules: 0 single, 1 add, 2 mul, 3 fma, 4 div.
  function automatic int cls_of(input logic [6:0] op, input logic [6:0] f7);
    if (op == 7'h43 || op == 7'h47 || op == 7'h4B || op == 7'h4F) return 3;
    if (op != 7'h53) return 0;
    case (f7[6:2])
      5'h00, 5'h01: return 1;
      5'h02:        return 2;
      5'h03, 5'h0B: return 4;
      default:      return 0;
    endcase
  endfunction

  function automatic int lat_of(input int c);
    case (c)
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 12;
      default: return 1;
    endcase
  endfunction

  // Model: an op occupies cycles (accept, end_cyc); completion fires at cmp_cyc.
  int         m_end = -1;
  int         m_cmp = -1;
  bit         m_wb  = 1'b0;
  logic [4:0] m_rd  = 5'd0;
  logic [2:0] m_cls = 3'd0;

  always @(negedge clk) begin : compare
    bit m_busy, m_acc, e_cmp, e_wb;
    int c;
    if (!rst_l) begin
      m_end = -1; m_cmp = -1; m_wb = 1'b0; m_rd = 5'd0; m_cls = 3'd0;
      chk("rst_halt", {31'd0, halt_req}, 0);
      chk("rst_dp", {31'd0, dp_start}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_cmp", {31'd0, fpu_complete}, 0);
      chk("rst_wb", {31'd0, wb_valid}, 0);
      chk("rst_wbrd", {27'd0, wb_rd}, 0);
      chk("rst_cls", {29'd0, op_class}, 0);
    end else begin
      c      = cls_of(inst_opcode, inst_funct7);
      m_busy = (cyc < m_end);
      m_acc  = !m_busy && inst_valid && fpu_active && !flush;
      e_cmp  = (m_cmp == cyc);
      e_wb   = e_cmp && m_wb;
      chk("halt_req", {31'd0, halt_req}, {31'd0, m_acc && c != 0});
      chk("dp_start", {31'd0, dp_start}, {31'd0, m_acc});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("fpu_complete", {31'd0, fpu_complete}, {31'd0, e_cmp});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wb});
      chk("wb_rd", {27'd0, wb_rd}, e_wb ? {27'd0, m_rd} : 32'd0);
      chk("op_class", {29'd0, op_class}, {29'd0, m_cls});
      if (m_acc) begin
        m_cls = 3'(c);
        m_rd  = inst_rd;
        m_end = cyc + lat_of(c);
        m_cmp = m_end;
        m_wb  = 1'b1;
      end else if (m_busy && flush && (cyc + 1 != m_end)) begin
        m_end = cyc + 1;
        m_cmp = cyc + 1;
        m_wb  = 1'b0;
      end
    end
  end

  task automatic drv(input bit iv, input bit fa, input logic [6:0] op,
                     input logic [6:0] f7, input logic [4:0] rd, input bit fl);
    @(posedge clk);
    #1;
    inst_valid = iv; fpu_active = fa; inst_opcode = op;
    inst_funct7 = f7; inst_rd = rd; flush = fl;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 7'h0, 7'h0, 5'd0, 0);
  endtask

  initial begin
    nop(3);
    @(posedge clk); #1; rst_l = 1'b1;
    nop(2);

    // 1. Reset mid-DIV: outputs drop at once, no completion afterwards.
    drv(1, 1, 7'h53, 7'h0C, 5'd11, 0);
    nop(4);
    @(posedge clk); #1; rst_l = 1'b0;
    #1;
    chk("lit_rst_busy", {31'd0, busy}, 0);
    chk("lit_rst_cls", {29'd0, op_class}, 0);
    nop(2);
    @(posedge clk); #1; rst_l = 1'b1;
    nop(14);

    // 2. ADD rd=7: halt+dp_start at T, complete at T+2.
    drv(1, 1, 7'h53, 7'h00, 5'd7, 0);
    @(negedge clk); chk("lit_add_halt", {31'd0, halt_req}, 1); chk("lit_add_dp", {31'd0, dp_start}, 1);
    nop(1);
    @(negedge clk); chk("lit_add_busy", {31'd0, busy}, 1); chk("lit_add_nocmp", {31'd0, fpu_complete}, 0);
    nop(1);
    @(negedge clk); chk("lit_add_cmp", {31'd0, fpu_complete}, 1); chk("lit_add_wbrd", {27'd0, wb_rd}, 7);
    nop(2);

    // 3. FMA with a strobe at T+2 that must be ignored.
    drv(1, 1, 7'h43, 7'h00, 5'd3, 0);
    nop(1);
    drv(1, 1, 7'h53, 7'h00, 5'd9, 0);
    @(negedge clk); chk("lit_fma_nohalt", {31'd0, halt_req}, 0); chk("lit_fma_cls", {29'd0, op_class}, 3);
    nop(2);
    @(negedge clk); chk("lit_fma_cmp", {31'd0, fpu_complete}, 1); chk("lit_fma_wbrd", {27'd0, wb_rd}, 3);
    nop(2);

    // 4. SINGLE: no halt, completes at T+1.
    drv(1, 1, 7'h53, 7'h70, 5'd12, 0);
    @(negedge clk); chk("lit_sgl_halt", {31'd0, halt_req}, 0); chk("lit_sgl_dp", {31'd0, dp_start}, 1);
    nop(1);
    @(negedge clk); chk("lit_sgl_wb", {31'd0, wb_valid}, 1); chk("lit_sgl_wbrd", {27'd0, wb_rd}, 12);
    nop(2);

    // 5. DIV flushed at T+5; ADD accepted in the abort-completion cycle.
    drv(1, 1, 7'h53, 7'h0C, 5'd5, 0);
    nop(4);
    drv(0, 0, 7'h0, 7'h0, 5'd0, 1);
    drv(1, 1, 7'h53, 7'h04, 5'd9, 0);
    @(negedge clk); chk("lit_fl_cmp", {31'd0, fpu_complete}, 1); chk("lit_fl_wb", {31'd0, wb_valid}, 0);
    chk("lit_fl_acc", {31'd0, halt_req}, 1);
    nop(2);
    @(negedge clk); chk("lit_fl_add_wbrd", {27'd0, wb_rd}, 9);
    nop(2);

    // 6. Back-to-back MUL: second accept in the first completion cycle.
    drv(1, 1, 7'h53, 7'h08, 5'd1, 0);
    nop(2);
    drv(1, 1, 7'h53, 7'h08, 5'd2, 0);
    @(negedge clk); chk("lit_b2b_halt", {31'd0, halt_req}, 1); chk("lit_b2b_wbrd", {27'd0, wb_rd}, 1);
    nop(3);
    @(negedge clk); chk("lit_b2b_cmp2", {31'd0, fpu_complete}, 1); chk("lit_b2b_wbrd2", {27'd0, wb_rd}, 2);
    nop(2);

    // Flush in IDLE blocks accept; fpu_active alone never starts an op.
    drv(1, 1, 7'h53, 7'h00, 5'd4, 1);
    @(negedge clk); chk("lit_idlefl_dp", {31'd0, dp_start}, 0);
    drv(0, 1, 7'h53, 7'h00, 5'd4, 0);
    @(negedge clk); chk("lit_faonly_dp", {31'd0, dp_start}, 0);
    drv(1, 0, 7'h53, 7'h00, 5'd4, 0);
    nop(2);

    // Flush coinciding with natural completion: writeback survives.
    drv(1, 1, 7'h53, 7'h00, 5'd20, 0);
    drv(0, 0, 7'h0, 7'h0, 5'd0, 1);
    @(negedge clk); chk("lit_flnat_busy", {31'd0, busy}, 1);
    nop(1);
    @(negedge clk); chk("lit_flnat_wb", {31'd0, wb_valid}, 1);
    nop(2);

    // Early flush of an FMA, then the remaining FMA opcodes, sqrt and sub via the model.
    drv(1, 1, 7'h4F, 7'h00, 5'd17, 0);
    drv(0, 0, 7'h0, 7'h0, 5'd0, 1);
    nop(3);
    drv(1, 1, 7'h47, 7'h00, 5'd21, 0); nop(5);
    drv(1, 1, 7'h4B, 7'h00, 5'd22, 0); nop(5);
    drv(1, 1, 7'h53, 7'h2C, 5'd31, 0); nop(14);
    drv(1, 1, 7'h53, 7'h1C, 5'd30, 0); nop(2);
    drv(1, 1, 7'h53, 7'h10, 5'd29, 0); nop(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
